// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with a one-cycle multiplier and a 32-step restoring divider.
// Operands are captured on start. Divides first work on magnitudes, then a FIX cycle applies the signs.
module hilo_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    input  logic              whi,
    input  logic              wlo,
    input  logic [DATA_W-1:0] wHiData,
    input  logic [DATA_W-1:0] wLoData,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] rHiData,
    output logic [DATA_W-1:0] rLoData
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam logic [1:0] OP_DIV = 2'b10;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic                done_q, done_d, dz_q, dz_d;

    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    logic [DATA_W:0]     shifted, trial;
    logic                neg_quo, neg_rem;

    // For signed div, 0x80000000 negates to itself, which reads as 2^31 unsigned.
    assign mag_a = (md_op == OP_DIV && opA[DATA_W-1]) ? -opA : opA;
    assign mag_b = (md_op == OP_DIV && opB[DATA_W-1]) ? -opB : opB;

    assign ext_a = op_q[0] ? {{DATA_W{1'b0}}, a_q} : {{DATA_W{a_q[DATA_W-1]}}, a_q};
    assign ext_b = op_q[0] ? {{DATA_W{1'b0}}, b_q} : {{DATA_W{b_q[DATA_W-1]}}, b_q};
    assign prod  = ext_a * ext_b;

    // The top bit of trial is set exactly when the shifted remainder is smaller than the divisor.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign neg_quo = (op_q == OP_DIV) && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
    assign neg_rem = (op_q == OP_DIV) && a_q[DATA_W-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (whi) hi_d = wHiData;
                if (wlo) lo_d = wLoData;
                if (start) begin
                    op_d  = md_op;
                    a_d   = opA;
                    b_d   = opB;
                    cnt_d = '0;
                    rem_d = '0;
                    quo_d = mag_a;
                    dvs_d = mag_b;
                    if (!md_op[1])       state_d = S_MUL;
                    else if (opB == '0)  state_d = S_FIX;
                    else                 state_d = S_DIV;
                end
            end
            S_MUL: begin
                {hi_d, lo_d} = prod;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            S_DIV: begin
                if (!trial[DATA_W]) begin
                    rem_d = trial[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
            end
            default: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (b_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else begin
                    hi_d = neg_rem ? -rem_q : rem_q;
                    lo_d = neg_quo ? -quo_q : quo_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign rHiData  = (whi && state_q == S_IDLE) ? wHiData : hi_q;
    assign rLoData  = (wlo && state_q == S_IDLE) ? wLoData : lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed vector table, multi-cycle corner sequences and
// random operations checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] opA = '0, opB = '0;
    logic        whi = 1'b0, wlo = 1'b0;
    logic [31:0] wHiData = '0, wLoData = '0;
    logic        busy, done, div_zero;
    logic [31:0] rHiData, rLoData;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_hi, last_lo;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.DATA_W(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op),
        .opA(opA), .opB(opB), .whi(whi), .wlo(wlo),
        .wHiData(wHiData), .wLoData(wLoData),
        .busy(busy), .done(done), .div_zero(div_zero),
        .rHiData(rHiData), .rLoData(rLoData)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          dz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
    // the remainder follows the dividend, which is the MIPS div rule.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output int lat, output bit dz);
        longint      sa, sb, sq, sr;
        logic [63:0] p, ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        lat = 1;
        hi = '0;
        lo = '0;
        if (op == 2'b00) begin
            p = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == 2'b01) begin
            p = ua * ub;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else if (op == 2'b10) begin
            sq = sa / sb;
            sr = sa % sb;
            hi = sr[31:0];
            lo = sq[31:0];
            lat = 33;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            hi = ur[31:0];
            lo = uq[31:0];
            lat = 33;
        end
    endfunction

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input bit edz);
        int n;
        bit bad_pulse;
        @(negedge clk);
        start = 1'b1; md_op = op; opA = a; opB = b;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        bad_pulse = 1'b0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            if (done !== 1'b0 || div_zero !== 1'b0) bad_pulse = 1'b1;
            n++;
            @(negedge clk);
        end
        check({nm, "/busy_cycles"}, 64'(n), 64'(elat));
        check({nm, "/pulse_while_busy"}, 64'(bad_pulse), 64'd0);
        check({nm, "/done"}, 64'(done), 64'd1);
        check({nm, "/div_zero"}, 64'(div_zero), 64'(edz));
        check({nm, "/hi"}, 64'(rHiData), 64'(ehi));
        check({nm, "/lo"}, 64'(rLoData), 64'(elo));
        $display("op %0d a=%08h b=%08h -> hi=%08h lo=%08h busy=%0d dz=%0d",
                 op, a, b, rHiData, rLoData, n, div_zero);
        @(negedge clk);
        check({nm, "/done_one_cycle"}, 64'({done, div_zero}), 64'd0);
        last_hi = ehi;
        last_lo = elo;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;
        logic [1:0]  rop;
        logic [31:0] ra, rb, ehi, elo;
        int          elat;
        bit          edz;

        vecs[0] = '{"mult_m3x7",   2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1,  1'b0};
        vecs[1] = '{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1,  1'b0};
        vecs[2] = '{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
        vecs[3] = '{"divu_100_7",  2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        33, 1'b0};
        vecs[4] = '{"divu_by0",    2'b11, 32'd100,       32'd0,        32'h64,        32'hFFFF_FFFF, 1,  1'b1};
        vecs[5] = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 1'b0};
        vecs[6] = '{"div_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 1'b0};
        vecs[7] = '{"div_by0",     2'b10, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 1,  1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'({done, div_zero}), 64'd0);
        check("reset/hi", 64'(rHiData), 64'd0);
        check("reset/lo", 64'(rLoData), 64'd0);

        // Direct write, then asynchronous reset in the middle of a cycle
        @(negedge clk);
        whi = 1'b1; wHiData = 32'hDEAD; wlo = 1'b1; wLoData = 32'hBEEF;
        @(posedge clk);
        #1 whi = 1'b0; wlo = 1'b0;
        check("wr/hi", 64'(rHiData), 64'hDEAD);
        check("wr/lo", 64'(rLoData), 64'hBEEF);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst/hi", 64'(rHiData), 64'd0);
        check("async_rst/lo", 64'(rLoData), 64'd0);
        check("async_rst/busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].lat, vecs[i].dz);

        // start and whi during a divide are both ignored
        @(negedge clk);
        start = 1'b1; md_op = 2'b11; opA = 32'd100; opB = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        start = 1'b1; md_op = 2'b00; opA = 32'd2; opB = 32'd2;
        whi = 1'b1; wHiData = 32'h55;
        #1;
        check("busy_ign/no_bypass", 64'(rHiData), 64'(last_hi));
        @(posedge clk);
        #1 start = 1'b0; whi = 1'b0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_ign/busy_cycles", 64'(n), 64'd33);
        check("busy_ign/done", 64'(done), 64'd1);
        check("busy_ign/hi", 64'(rHiData), 64'd2);
        check("busy_ign/lo", 64'(rLoData), 64'd14);
        $display("op 3 a=00000064 b=00000007 with ignored start/whi -> hi=%08h lo=%08h busy=%0d",
                 rHiData, rLoData, n);

        // Read bypass in IDLE, registered on the edge
        @(negedge clk);
        whi = 1'b1; wHiData = 32'h1234;
        #1;
        check("bypass/same_cycle", 64'(rHiData), 64'h1234);
        @(posedge clk);
        #1 whi = 1'b0; wHiData = 32'h0;
        check("bypass/after_edge", 64'(rHiData), 64'h1234);
        check("bypass/lo_kept", 64'(rLoData), 64'd14);

        // Reset at divide iteration 10 discards everything
        @(negedge clk);
        start = 1'b1; md_op = 2'b10; opA = 32'd1000; opB = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_div_rst/busy", 64'(busy), 64'd0);
        check("mid_div_rst/hi", 64'(rHiData), 64'd0);
        check("mid_div_rst/lo", 64'(rLoData), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("mid_div_rst/no_done", 64'(bad), 64'd0);
        run_op("after_rst_mult", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1, 1'b0);

        // Random operations against the model
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(rop, ra, rb, ehi, elo, elat, edz);
            run_op($sformatf("rand%0d", i), rop, ra, rb, ehi, elo, elat, edz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
